// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Responder end of the data-memory load/store port. A request (read_En or
// write_En, held by the initiator until ready) is captured, delayed by
// WAIT_CYCLES wait states, then performed as a byte/half/word access on an
// internal little-endian RAM. Completion is signalled by a one-cycle ready
// pulse in the DONE state; misaligned/illegal accesses pulse misaligned and
// leave the RAM untouched.
//
// Optional feature macro: STALL_COUNTER_EN
//   defined   : stall_count counts cycles with a pending, not-ready request
//               (saturating, cleared only by reset)
//   undefined : counter removed, stall_count tied to zero
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int MEMORY_DEPTH  = 4096,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int WAIT_CYCLES   = 2
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     read_En,
    input  logic                     write_En,
    input  logic [2:0]               func3,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     ready,
    output logic                     misaligned,
    output logic [31:0]              stall_count
);

    // Address geometry: byte-address bits used inside the RAM
    localparam int LP_AB    = $clog2(MEMORY_DEPTH);
    localparam int LP_IW    = (LP_AB > 2) ? (LP_AB - 2) : 1;
    localparam int LP_AL    = LP_IW + 2;
    localparam int LP_WORDS = MEMORY_DEPTH / 4;
    localparam logic [LP_IW-1:0] LP_IDX_MASK = LP_IW'(LP_WORDS - 1);

    // Wait-state bookkeeping
    localparam bit         LP_HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [7:0] LP_LAST     = 8'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Access helpers
    // ------------------------------------------------------------------
    // Illegal when the width does not fit the lane or the encoding is unused
    function automatic logic f_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] lane);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = lane[0];
            3'b010:  bad = (lane != 2'b00);
            3'b100:  bad = we;
            3'b101:  bad = we | lane[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Select the addressed lane of a RAM word and extend it
    function automatic logic [31:0] f_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Merge right-aligned store data into the addressed lane(s)
    function automatic logic [31:0] f_store(input logic [31:0] old, input logic [2:0] f3,
                                            input logic [1:0] lane, input logic [31:0] wd);
        logic [31:0] res;
        res = old;
        case (f3)
            3'b000: res[{lane, 3'b000} +: 8] = wd[7:0];
            3'b001: begin
                if (lane[1]) begin
                    res[31:16] = wd[15:0];
                end else begin
                    res[15:0] = wd[15:0];
                end
            end
            3'b010:  res = wd;
            default: res = old;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_nxt;
    logic               r_we;
    logic [2:0]         r_f3;
    logic [LP_AL-1:0]   r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_data_out;
    logic               r_misaligned;
    logic [31:0]        r_mem [LP_WORDS];

    logic               w_req;
    logic               w_capture;
    logic               w_do_access;
    logic               w_use_in;
    logic               w_acc_we;
    logic [2:0]         w_acc_f3;
    logic [LP_AL-1:0]   w_acc_addr;
    logic [31:0]        w_acc_wdata;
    logic [1:0]         w_lane;
    logic [LP_IW-1:0]   w_idx;
    logic [31:0]        w_mem_word;
    logic               w_illegal;
    logic               w_unused_addr;

    assign w_req         = read_En | write_En;
    assign ready         = ((r_state == ST_IDLE) & ~w_req) | (r_state == ST_DONE);
    assign data_out      = r_data_out;
    assign misaligned    = r_misaligned;
    assign w_unused_addr = ^address[ADDRESS_WIDTH-1:LP_AL];

    // Next-state, wait counter and access strobe
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_do_access = 1'b0;
        w_use_in    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_capture = 1'b1;
                    w_cnt_nxt = 8'd0;
                    if (LP_HAS_WAIT) begin
                        w_state_nxt = ST_BUSY;
                    end else begin
                        w_do_access = 1'b1;
                        w_use_in    = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!w_req) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt == LP_LAST) begin
                        w_do_access = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Access operands: live inputs for zero-wait requests, captured copy otherwise
    always_comb begin
        if (w_use_in) begin
            w_acc_we    = write_En;
            w_acc_f3    = func3;
            w_acc_addr  = address[LP_AL-1:0];
            w_acc_wdata = data_in;
        end else begin
            w_acc_we    = r_we;
            w_acc_f3    = r_f3;
            w_acc_addr  = r_addr;
            w_acc_wdata = r_wdata;
        end
    end

    assign w_lane     = w_acc_addr[1:0];
    assign w_idx      = w_acc_addr[LP_AL-1:2] & LP_IDX_MASK;
    assign w_mem_word = r_mem[w_idx];
    assign w_illegal  = f_illegal(w_acc_we, w_acc_f3, w_lane);

    // FSM state, wait counter and request capture
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_we    <= write_En;
                r_f3    <= func3;
                r_addr  <= address[LP_AL-1:0];
                r_wdata <= data_in;
            end
        end
    end

    // Registered load result and one-cycle misaligned flag
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_data_out   <= 32'd0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_do_access & w_illegal;
            if (w_do_access) begin
                if (w_acc_we || w_illegal) begin
                    r_data_out <= 32'd0;
                end else begin
                    r_data_out <= f_load(w_mem_word, w_acc_f3, w_lane);
                end
            end
        end
    end

    // RAM write port; contents survive reset, writes blocked while in reset
    always_ff @(posedge clk) begin
        if (w_do_access && w_acc_we && !w_illegal && rstN) begin
            r_mem[w_idx] <= f_store(w_mem_word, w_acc_f3, w_lane, w_acc_wdata);
        end
    end

`ifdef STALL_COUNTER_EN
    logic [31:0] r_stall_count;

    // Saturating count of cycles the initiator is held off
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_stall_count <= 32'd0;
        end else if (w_req && !ready && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed vector table, hand-written abort/reset/stall sequences, a
// zero-wait-state instance, and randomized traffic checked against a
// byte-array reference model.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rstN;
    logic        read_En, write_En;
    logic [2:0]  func3;
    logic [31:0] address, data_in;
    logic [31:0] data_out, stall_count;
    logic        ready, misaligned;

    logic        read_En_0, write_En_0;
    logic [2:0]  func3_0;
    logic [31:0] address_0, data_in_0;
    logic [31:0] data_out_0, stall_count_0;
    logic        ready_0, misaligned_0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.MEMORY_DEPTH(4096), .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rstN(rstN), .read_En(read_En), .write_En(write_En), .func3(func3),
        .address(address), .data_in(data_in), .data_out(data_out), .ready(ready),
        .misaligned(misaligned), .stall_count(stall_count)
    );

    dmem_responder #(.MEMORY_DEPTH(4096), .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rstN(rstN), .read_En(read_En_0), .write_En(write_En_0), .func3(func3_0),
        .address(address_0), .data_in(data_in_0), .data_out(data_out_0), .ready(ready_0),
        .misaligned(misaligned_0), .stall_count(stall_count_0)
    );

    // ---------------- reference model (byte-addressed RAM) ----------------
    logic [7:0] m_mem [0:4095];

    function automatic bit m_illegal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (we) ok = (f3 == 3'd0) || (f3 == 3'd1 && a % 2 == 0) || (f3 == 3'd2 && a % 4 == 0);
        else    ok = (f3 == 3'd0) || (f3 == 3'd4) || ((f3 == 3'd1 || f3 == 3'd5) && a % 2 == 0)
                     || (f3 == 3'd2 && a % 4 == 0);
        return !ok;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        int unsigned base, v;
        base = a % 4096;
        case (f3)
            3'd0, 3'd4: v = m_mem[base];
            3'd1, 3'd5: v = m_mem[base] + 256 * m_mem[base + 1];
            default:    v = m_mem[base] + (m_mem[base + 1] << 8) + (m_mem[base + 2] << 16)
                            + (m_mem[base + 3] << 24);
        endcase
        if (f3 == 3'd0 && v >= 128)   v = v + 32'hFFFF_FF00;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) m_mem[(a % 4096) + k] = 8'((wd >> (8 * k)) & 32'hFF);
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    // One complete request on the WAIT_CYCLES=2 instance; low = cycles with ready=0
    task automatic run_req(input logic we, input logic re, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] d, output logic mis, output int low);
        @(negedge clk);
        write_En = we; read_En = re; func3 = f3; address = a; data_in = wd;
        #1;
        low = 0;
        while (ready !== 1'b1 && low < 300) begin
            low++;
            @(negedge clk);
            #1;
        end
        d   = data_out;
        mis = misaligned;
        write_En = 1'b0; read_En = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic        re;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk_d;
        logic [31:0] exp_d;
        logic        exp_m;
    } vec_t;

    vec_t        tbl [21];
    logic [31:0] d;
    logic        mis;
    int          low;
    logic [31:0] s0;

    initial begin
        // ---------------- directed table ----------------
        tbl[0]  = '{1'b1, 1'b0, 3'd2, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3'd2, 32'h10,   32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'd0, 32'h13,   32'h000000AA, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 1'b1, 3'd0, 32'h13,   32'h0,        1'b1, 32'hFFFFFFAA, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 3'd4, 32'h13,   32'h0,        1'b1, 32'h000000AA, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'd2, 32'h10,   32'h0,        1'b1, 32'hAAADBEEF, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3'd1, 32'h11,   32'h0,        1'b1, 32'h0,        1'b1};
        tbl[7]  = '{1'b1, 1'b0, 3'd2, 32'h12,   32'h12345678, 1'b0, 32'h0,        1'b1};
        tbl[8]  = '{1'b0, 1'b1, 3'd2, 32'h10,   32'h0,        1'b1, 32'hAAADBEEF, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 3'd2, 32'h14,   32'h11223344, 1'b0, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'd1, 32'h16,   32'h00008001, 1'b0, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 1'b1, 3'd1, 32'h16,   32'h0,        1'b1, 32'hFFFF8001, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 3'd5, 32'h16,   32'h0,        1'b1, 32'h00008001, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 3'd2, 32'h1014, 32'h0,        1'b1, 32'h80013344, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 3'd3, 32'h14,   32'h0,        1'b1, 32'h0,        1'b1};
        tbl[15] = '{1'b1, 1'b0, 3'd4, 32'h14,   32'h000000FF, 1'b0, 32'h0,        1'b1};
        tbl[16] = '{1'b0, 1'b1, 3'd4, 32'h14,   32'h0,        1'b1, 32'h00000044, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 3'd2, 32'h18,   32'hCAFEF00D, 1'b1, 32'h0,        1'b0};
        tbl[18] = '{1'b0, 1'b1, 3'd2, 32'h18,   32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 3'd0, 32'h17,   32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 3'd2, 32'h12,   32'h0,        1'b1, 32'h0,        1'b1};

        rstN = 1'b0;
        read_En = 1'b0; write_En = 1'b0; func3 = 3'd0; address = 32'd0; data_in = 32'd0;
        read_En_0 = 1'b0; write_En_0 = 1'b0; func3_0 = 3'd0; address_0 = 32'd0; data_in_0 = 32'd0;
        #1;
        chk("reset ready", {31'd0, ready}, 32'd1);
        chk("reset data_out", data_out, 32'd0);
        chk("reset misaligned", {31'd0, misaligned}, 32'd0);
        chk("reset stall_count", stall_count, 32'd0);
        @(negedge clk); @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < 21; i++) begin
            run_req(tbl[i].we, tbl[i].re, tbl[i].f3, tbl[i].addr, tbl[i].wd, d, mis, low);
            chk($sformatf("vec%0d latency", i), low, 32'd3);
            chk($sformatf("vec%0d misaligned", i), {31'd0, mis}, {31'd0, tbl[i].exp_m});
            if (tbl[i].chk_d) chk($sformatf("vec%0d data_out", i), d, tbl[i].exp_d);
            @(negedge clk); #1;
            chk($sformatf("vec%0d misaligned after DONE", i), {31'd0, misaligned}, 32'd0);
        end

        // ---------------- abort after one BUSY cycle ----------------
        run_req(1'b1, 1'b0, 3'd2, 32'h20, 32'h55AA55AA, d, mis, low);
        @(negedge clk);
        write_En = 1'b1; func3 = 3'd2; address = 32'h20; data_in = 32'h00000001;
        @(negedge clk);
        write_En = 1'b0;
        @(negedge clk); #1;
        chk("abort ready", {31'd0, ready}, 32'd1);
        run_req(1'b0, 1'b1, 3'd2, 32'h20, 32'h0, d, mis, low);
        chk("abort no write", d, 32'h55AA55AA);

        // ---------------- reset mid-BUSY ----------------
        @(negedge clk);
        write_En = 1'b1; func3 = 3'd2; address = 32'h20; data_in = 32'h0BADF00D;
        @(negedge clk); #1;
        rstN = 1'b0; write_En = 1'b0;
        #1;
        chk("midreset ready", {31'd0, ready}, 32'd1);
        chk("midreset data_out", data_out, 32'd0);
        chk("midreset stall_count", stall_count, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        run_req(1'b0, 1'b1, 3'd2, 32'h20, 32'h0, d, mis, low);
        chk("midreset no write", d, 32'h55AA55AA);

        // ---------------- stall counter over three loads ----------------
        s0 = stall_count;
        for (int i = 0; i < 3; i++) run_req(1'b0, 1'b1, 3'd2, 32'h10, 32'h0, d, mis, low);
`ifdef STALL_COUNTER_EN
        chk("stall_count delta", stall_count - s0, 32'd9);
`else
        chk("stall_count delta", stall_count - s0, 32'd0);
        chk("stall_count tied", stall_count, 32'd0);
`endif

        // ---------------- zero-wait instance ----------------
        @(negedge clk);
        write_En_0 = 1'b1; func3_0 = 3'd2; address_0 = 32'h40; data_in_0 = 32'h0F1E2D3C;
        #1 chk("w0 store ready low", {31'd0, ready_0}, 32'd0);
        @(negedge clk); #1;
        chk("w0 store ready high", {31'd0, ready_0}, 32'd1);
        write_En_0 = 1'b0;
        @(negedge clk);
        read_En_0 = 1'b1; func3_0 = 3'd2; address_0 = 32'h40;
        #1 chk("w0 load ready low", {31'd0, ready_0}, 32'd0);
        @(negedge clk); #1;
        chk("w0 load ready high", {31'd0, ready_0}, 32'd1);
        chk("w0 load data", data_out_0, 32'h0F1E2D3C);
        read_En_0 = 1'b0;

        // ---------------- randomized traffic vs. model ----------------
        for (int i = 0; i < 64; i++) begin
            logic [31:0] wd;
            wd = $urandom;
            run_req(1'b1, 1'b0, 3'd2, 32'(i * 4), wd, d, mis, low);
            m_store(3'd2, 32'(i * 4), wd);
        end
        for (int i = 0; i < 150; i++) begin
            logic        we, re, em;
            logic [2:0]  f3;
            logic [31:0] a, wd;
            we = 1'($urandom_range(0, 1));
            re = we ? ($urandom_range(0, 3) == 0) : 1'b1;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom & 32'hFFFF_F0FF;
            wd = $urandom;
            em = m_illegal(we, f3, a);
            run_req(we, re, f3, a, wd, d, mis, low);
            chk($sformatf("rnd%0d latency", i), low, 32'd3);
            chk($sformatf("rnd%0d misaligned", i), {31'd0, mis}, {31'd0, em});
            if (!we) chk($sformatf("rnd%0d data_out", i), d, em ? 32'd0 : m_load(f3, a));
            if (we && !em) m_store(f3, a, wd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
